// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit/receive peripherals: register map,
// STATUS bit positions and frame geometry.
package i2s_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned BitCntW    = $clog2(FRAME_BITS);

  // Word offsets, decoded from HADDR[3:2]
  typedef enum logic [1:0] {
    RegData     = 2'd0,
    RegStatus   = 2'd1,
    RegCtrl     = 2'd2,
    RegPrescale = 2'd3
  } reg_addr_e;

  localparam int unsigned StatFull     = 0;
  localparam int unsigned StatEmpty    = 1;
  localparam int unsigned StatUnderrun = 2;
  localparam int unsigned StatOverflow = 3;
  localparam int unsigned StatLevelLsb = 4;

  // WS leads the channel by one bit: high for the last left bit through the
  // second-to-last right bit.
  function automatic logic ws_for_bit(input logic [BitCntW-1:0] cnt);
    return (cnt >= BitCntW'(15)) && (cnt <= BitCntW'(FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed stereo frames.
module i2s_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (PtrW + 1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted when a pop frees a slot this cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite slave feeding a stereo I2S transmitter: register block, frame FIFO,
// bit-clock divider and frame serialiser.
module ahbl_i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  PRESCALE_RST = 8'd3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        i2s_clk,
  output logic        ws,
  output logic        sd
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  // Bus address/data phase
  logic      wr_q;
  reg_addr_e addr_q;
  logic      data_wr, status_wr, ctrl_wr, prescale_wr;
  logic      unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};
  assign HREADYOUT   = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      addr_q <= RegData;
    end else if (HREADY) begin
      wr_q <= HSEL & HTRANS[1] & HWRITE;
      if (HSEL && HTRANS[1]) addr_q <= reg_addr_e'(HADDR[3:2]);
    end
  end

  assign data_wr     = wr_q && (addr_q == RegData);
  assign status_wr   = wr_q && (addr_q == RegStatus);
  assign ctrl_wr     = wr_q && (addr_q == RegCtrl);
  assign prescale_wr = wr_q && (addr_q == RegPrescale);

  // Control/status registers
  logic       en_q, en_d;
  logic [7:0] prescale_q;
  logic       underrun_q, overflow_q;
  logic       underrun_evt, overflow_evt;

  assign en_d = ctrl_wr ? HWDATA[0] : en_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      en_q <= en_d;
      if (prescale_wr) prescale_q <= HWDATA[7:0];
      // A fresh event wins over a simultaneous write-1-to-clear
      underrun_q <= (underrun_q & ~(status_wr & HWDATA[StatUnderrun])) | underrun_evt;
      overflow_q <= (overflow_q & ~(status_wr & HWDATA[StatOverflow])) | overflow_evt;
    end
  end

  // Frame FIFO
  logic [31:0]     fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [LvlW-1:0] fifo_level;

  i2s_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (FRAME_BITS)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (data_wr),
    .wdata_i (HWDATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Bit clock divider and serialiser
  logic [7:0]         div_cnt_q, div_lim_q;
  logic               sck_q, ws_q, sd_q, loaded_q;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_inc;
  logic [31:0]        shift_q, frame_word;
  logic               tick, fall, load;

  assign tick         = en_q && en_d && (div_cnt_q == div_lim_q);
  assign fall         = tick && sck_q;
  // The first falling edge after enable, and the edge closing bit 31, load a frame
  assign load         = fall && (!loaded_q || (bit_cnt_q == BitCntW'(FRAME_BITS - 1)));
  assign fifo_pop     = load && !fifo_empty;
  assign underrun_evt = load && fifo_empty;
  assign overflow_evt = data_wr && fifo_full && !fifo_pop;
  assign frame_word   = fifo_empty ? 32'h0 : fifo_rdata;
  assign bit_cnt_inc  = bit_cnt_q + 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt_q <= '0;
      div_lim_q <= PRESCALE_RST;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      loaded_q  <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (!en_d) begin
      // Disabled: hold everything cleared; the divider limit tracks PRESCALE
      div_cnt_q <= '0;
      div_lim_q <= prescale_q;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      loaded_q  <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (en_q) begin
      if (tick) begin
        div_cnt_q <= '0;
        div_lim_q <= prescale_q;
        sck_q     <= ~sck_q;
        if (load) begin
          sd_q      <= frame_word[31];
          shift_q   <= {frame_word[30:0], 1'b0};
          bit_cnt_q <= '0;
          ws_q      <= 1'b0;
          loaded_q  <= 1'b1;
        end else if (fall) begin
          sd_q      <= shift_q[31];
          shift_q   <= {shift_q[30:0], 1'b0};
          bit_cnt_q <= bit_cnt_inc;
          ws_q      <= ws_for_bit(bit_cnt_inc);
        end
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  assign i2s_clk = sck_q;
  assign ws      = ws_q;
  assign sd      = sd_q;

  // Read mux
  logic [3:0] level_rd;

  always_comb begin
    level_rd = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);
    HRDATA   = '0;
    unique case (addr_q)
      RegStatus: begin
        HRDATA[StatFull]                       = fifo_full;
        HRDATA[StatEmpty]                      = fifo_empty;
        HRDATA[StatUnderrun]                   = underrun_q;
        HRDATA[StatOverflow]                   = overflow_q;
        HRDATA[StatLevelLsb+3:StatLevelLsb]    = level_rd;
      end
      RegCtrl:     HRDATA[0]   = en_q;
      RegPrescale: HRDATA[7:0] = prescale_q;
      default:     HRDATA      = '0;
    endcase
  end

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
// Directed bench for ahbl_i2s_tx: bus register access, serial framing, FIFO
// boundaries, enable/disable and mid-frame reset.
module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        i2s_clk, ws, sd;

  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_CTRL = 32'h8, A_PRE = 32'hC;

  ahbl_i2s_tx dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .i2s_clk   (i2s_clk),
    .ws        (ws),
    .sd        (sd)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  // Returns HCLK cycles until the next i2s_clk rising edge, or -1 on timeout
  task automatic wait_rise(output int cyc);
    logic prev;
    prev = i2s_clk;
    cyc  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge HCLK);
      cyc++;
      if (!prev && i2s_clk) return;
      prev = i2s_clk;
    end
    check("sck_rise_timeout", 64'd0, 64'd1);
    cyc = -1;
  endtask

  // Samples sd/ws on n rising edges, first bit ends up most significant
  task automatic capture(input int n, output logic [63:0] sdb, output logic [63:0] wsb,
                         output int gmin, output int gmax);
    int cyc;
    sdb = '0; wsb = '0; gmin = 1000; gmax = 0;
    for (int i = 0; i < n; i++) begin
      wait_rise(cyc);
      if (cyc < 0) return;
      sdb = {sdb[62:0], sd};
      wsb = {wsb[62:0], ws};
      if (i > 0) begin
        if (cyc < gmin) gmin = cyc;
        if (cyc > gmax) gmax = cyc;
      end
    end
  endtask

  logic [31:0] rd;
  logic [63:0] sdb, wsb;
  int          gmin, gmax, cyc;
  logic [31:0] s3_vals [5];

  initial begin
    s3_vals[0] = 32'h1111_2222; s3_vals[1] = 32'h3333_4444; s3_vals[2] = 32'h5555_6666;
    s3_vals[3] = 32'h7777_8888; s3_vals[4] = 32'hDEAD_BEEF;

    // Reset state
    do_reset();
    check("rst_outputs", {61'd0, i2s_clk, ws, sd}, 64'd0);
    check("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    bus_read(A_STATUS, rd);   check("rst_status", rd, 64'h2);
    bus_read(A_CTRL, rd);     check("rst_ctrl", rd, 64'h0);
    bus_read(A_PRE, rd);      check("rst_prescale", rd, 64'h3);
    bus_read(A_DATA, rd);     check("rst_data_read", rd, 64'h0);

    // Scenario 1: single frame, PRESCALE=1
    bus_write(A_PRE, 32'h1);
    bus_read(A_PRE, rd);      check("s1_prescale_rw", rd, 64'h1);
    bus_write(A_DATA, 32'hA5A5_3C3C);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, rd);     check("s1_ctrl_rw", rd, 64'h1);
    wait_rise(cyc);
    capture(32, sdb, wsb, gmin, gmax);
    check("s1_sd", sdb[31:0], 64'hA5A5_3C3C);
    check("s1_ws", wsb[31:0], 64'h0001_FFFE);
    check("s1_period_min", gmin, 64'd4);
    check("s1_period_max", gmax, 64'd4);

    // Scenario 2: underrun on empty FIFO
    do_reset();
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    capture(32, sdb, wsb, gmin, gmax);
    check("s2_sd_zero", sdb[31:0], 64'h0);
    check("s2_period", gmax, 64'd8);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd);   check("s2_status_underrun", rd, 64'h6);
    bus_write(A_STATUS, 32'h4);
    bus_read(A_STATUS, rd);   check("s2_status_cleared", rd, 64'h2);

    // Scenario 3: overflow with depth 4, fifth value dropped
    do_reset();
    for (int i = 0; i < 5; i++) bus_write(A_DATA, s3_vals[i]);
    bus_read(A_STATUS, rd);   check("s3_status_full_ovf", rd, 64'h49);
    bus_write(A_STATUS, 32'h8);
    bus_read(A_STATUS, rd);   check("s3_overflow_w1c", rd, 64'h41);
    bus_write(A_PRE, 32'h0);
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    for (int f = 0; f < 4; f++) begin
      capture(32, sdb, wsb, gmin, gmax);
      check($sformatf("s3_frame%0d", f), sdb[31:0], {32'd0, s3_vals[f]});
    end
    capture(32, sdb, wsb, gmin, gmax);
    check("s3_fifth_dropped", sdb[31:0], 64'h0);

    // Scenario 4: back-to-back frames
    do_reset();
    bus_write(A_PRE, 32'h1);
    bus_write(A_DATA, 32'h1234_5678);
    bus_write(A_DATA, 32'h9ABC_DEF0);
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    capture(64, sdb, wsb, gmin, gmax);
    check("s4_two_frames", sdb, 64'h1234_5678_9ABC_DEF0);
    check("s4_no_gap_min", gmin, 64'd4);
    check("s4_no_gap_max", gmax, 64'd4);

    // Scenario 5: disable mid-left, then re-enable on the next frame
    do_reset();
    bus_write(A_DATA, 32'hC0DE_1234);
    bus_write(A_DATA, 32'h8765_4321);
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    capture(2, sdb, wsb, gmin, gmax);
    check("s5_first_bits", sdb[1:0], 64'h3);
    check("s5_sck_high", {63'd0, i2s_clk}, 64'd1);
    bus_write(A_CTRL, 32'h0);
    check("s5_outputs_low", {61'd0, i2s_clk, ws, sd}, 64'd0);
    bus_read(A_STATUS, rd);   check("s5_level_kept", rd, 64'h10);
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    capture(32, sdb, wsb, gmin, gmax);
    check("s5_next_frame", sdb[31:0], 64'h8765_4321);

    // Scenario 6: reset during bit 20 (right channel, ws high)
    do_reset();
    bus_write(A_PRE, 32'h5);
    bus_write(A_DATA, 32'hFFFF_FFFF);
    bus_write(A_CTRL, 32'h1);
    wait_rise(cyc);
    capture(21, sdb, wsb, gmin, gmax);
    check("s6_mid_frame_ws_sd", {62'd0, ws, sd}, 64'h3);
    HRESETn = 1'b0;
    #1;
    check("s6_outputs_reset", {61'd0, i2s_clk, ws, sd}, 64'd0);
    check("s6_hrdata_reset", HRDATA, 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    bus_read(A_CTRL, rd);     check("s6_ctrl", rd, 64'h0);
    bus_read(A_PRE, rd);      check("s6_prescale", rd, 64'h3);
    bus_read(A_STATUS, rd);   check("s6_status", rd, 64'h2);
    repeat (20) @(negedge HCLK);
    check("s6_idle_after", {61'd0, i2s_clk, ws, sd}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahbl_i2s_tx.md
AHBL_I2S_TX -- requirements
Module: ahbl_i2s_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, stereo frames buffered (power of two, 2..16).
REQ-002 Parameter PRESCALE_RST, default 8'd3, reset value of PRESCALE register.
REQ-003 HCLK  input  1  sole clock.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 HADDR  input  32  AHB-Lite address; only [3:2] decoded.
REQ-006 HTRANS  input  2  transfer type.
REQ-007 HSIZE  input  3  transfer size; word accesses only, others treated as word.
REQ-008 HWRITE  input  1  write strobe.
REQ-009 HREADY  input  1  bus ready.
REQ-010 HSEL  input  1  slave select.
REQ-011 HWDATA  input  32  write data.
REQ-012 HREADYOUT  output  1  always 1, zero wait states.
REQ-013 HRDATA  output  32  read data.
REQ-014 i2s_clk  output  1  serial bit clock (SCK).
REQ-015 ws  output  1  word select; 0 = left, 1 = right.
REQ-016 sd  output  1  serial data, MSB first.

Function
REQ-017 Address phase is latched when HSEL & HTRANS[1] & HREADY; the write or read side effect occurs in the following data-phase cycle.
REQ-018 Register map: 0x0 DATA (W: push {left[31:16], right[15:0]}; R: 0), 0x4 STATUS (R: bit0 full, bit1 empty, bit2 underrun, bit3 overflow, [7:4] fill level; W: write-1-to-clear bits 2/3), 0x8 CTRL (bit0 EN, R/W), 0xC PRESCALE ([7:0], R/W).
REQ-019 HRDATA is combinational from the latched address; unused bits read 0.
REQ-020 A DATA write while full is dropped and sets overflow; FIFO contents are unchanged.
REQ-021 With EN=1, i2s_clk toggles every PRESCALE+1 HCLK cycles, giving a period of 2*(PRESCALE+1) HCLK cycles.
REQ-022 sd and ws change only on i2s_clk falling edges. Receivers sample on rising edges.
REQ-023 Frame is 32 SCK bits with bit_cnt 0..31. Bits 0..15 carry left[15:0] and bits 16..31 carry right[15:0], both MSB first.
REQ-024 ws = 1 while bit_cnt is in 15..30, otherwise 0. This gives the standard I2S one-bit WS lead.
REQ-025 On the falling edge ending bit 31, or on the first falling edge after EN rises, the next frame is popped into a 32-bit shift register.
REQ-026 If the FIFO is empty at a load point, an all-zero frame is sent and underrun is set.
REQ-027 A simultaneous push and pop in one HCLK cycle keeps the fill level unchanged.
REQ-028 A push to a full FIFO coinciding with a pop is accepted.
REQ-029 Clearing EN stops immediately: i2s_clk, ws, sd and sd go low; divider, bit counter and shift register clear. FIFO contents are retained.
REQ-030 A PRESCALE write takes effect at the next divider reload.
REQ-031 A W1C write to STATUS coinciding with a new underrun/overflow event leaves the flag set.

Reset
REQ-032 On HRESETn low: i2s_clk, ws, sd = 0; HRDATA = 0; HREADYOUT = 1; FIFO empty; CTRL = 0; PRESCALE = PRESCALE_RST; underrun/overflow = 0; counters = 0.
REQ-033 Reset asserted mid-frame aborts the frame; no partial data is retained.

Structure
REQ-034 Shared package i2s_pkg holds register offsets, STATUS bit indices, and FRAME_BITS = 32, for reuse by ahbl_i2s_rx.
REQ-035 One sub-module, i2s_tx_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised by FIFO_DEPTH.

Verification
REQ-036 Scenario 1: PRESCALE=1, push 0xA5A5_3C3C, EN=1 -> i2s_clk period 4 HCLK; sd serialises 1010010110100101 then 0011110000111100; ws rises after left bit 14 and falls after right bit 14.
REQ-037 Scenario 2: EN=1 with FIFO empty -> sd stays 0 for a full frame; STATUS reads 0x6 (empty | underrun); writing 0x4 to STATUS clears underrun to 0x2.
REQ-038 Scenario 3: five DATA writes with depth 4 and EN=0 -> STATUS = 0x49 (level 4, full, overflow); the fifth value never appears on sd.
REQ-039 Scenario 4: push 0x1234_5678 then 0x9ABC_DEF0 -> frames are emitted back to back, with no gap cycle between bit 31 and the next bit 0.
REQ-040 Scenario 5: clear EN mid-left-channel -> i2s_clk, ws and sd are low the next HCLK; STATUS level is unchanged; re-enabling starts at bit 0 of the next queued frame.
REQ-041 Scenario 6: assert HRESETn low during bit 20 -> all outputs 0, CTRL reads 0, PRESCALE reads 0x03, STATUS reads 0x2.
